// File: rtl/barrel_shift_arbiter.sv
// barrel_shift_arbiter: shares one 8-bit barrel rotator between NREQ requesters.
// Optional build macro: BSH_ARB_FIXED_PRIO_EN (fixed priority, lowest index wins).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req_valid  command valid, one bit per requester
//   req_ready  command accepted (one-hot or zero, IDLE only)
//   req_data   8-bit operand per requester, requester i at [8i+7:8i]
//   req_lr     direction per requester: 0 = rotate left, 1 = rotate right
//   req_sha    3-bit rotate amount per requester, requester i at [3i+2:3i]
//   rsp_valid  result valid for the owning requester (one-hot or zero)
//   rsp_ready  requester takes its result
//   rsp_data   registered rotated result, qualified by rsp_valid
//   bsh_in     registered operand to the rotator
//   bsh_lr     registered direction to the rotator
//   bsh_sha    registered amount to the rotator
//   bsh_out    combinational result from the rotator
//   busy       high whenever a command is in flight
//   grant_id   index of the requester owning the rotator
module barrel_shift_arbiter #(
    parameter  int NREQ = 4,
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_lr,
    input  logic [3*NREQ-1:0] req_sha,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [7:0]        rsp_data,
    output logic [7:0]        bsh_in,
    output logic              bsh_lr,
    output logic [2:0]        bsh_sha,
    input  logic [7:0]        bsh_out,
    output logic              busy,
    output logic [ID_W-1:0]   grant_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic            any_valid;
    logic [ID_W-1:0] win_id;
    logic [NREQ-1:0] win_oh;
    logic [NREQ-1:0] own_oh;
    logic            accept;
    logic            finish;
    logic [7:0]      sel_data;
    logic            sel_lr;
    logic [2:0]      sel_sha;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef BSH_ARB_FIXED_PRIO_EN
    // Descending scan: the last hit is the lowest valid index.
    always_comb begin
        win_id    = '0;
        any_valid = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win_id    = ID_W'(i);
                any_valid = 1'b1;
            end
        end
    end
`else
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] rr_nxt;

    // Scan offsets from farthest to nearest so that the last hit is the
    // first valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        win_id    = '0;
        any_valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                win_id    = ID_W'((int'(rr_ptr) + k) % NREQ);
                any_valid = 1'b1;
            end
        end
    end

    // Pointer moves past the owner only once its response is taken.
    always_comb begin
        rr_nxt = ID_W'((int'(grant_id) + 1) % NREQ);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (finish) begin
            rr_ptr <= rr_nxt;
        end
    end
`endif

    // ------------------------------------------------------------------
    // One-hot decode of winner and owner, operand select
    // ------------------------------------------------------------------
    always_comb begin
        win_oh = '0;
        own_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            win_oh[i] = (win_id == ID_W'(i));
            own_oh[i] = (grant_id == ID_W'(i));
        end
    end

    always_comb begin
        sel_data = '0;
        sel_lr   = 1'b0;
        sel_sha  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_id == ID_W'(i)) begin
                sel_data = req_data[8*i +: 8];
                sel_lr   = req_lr[i];
                sel_sha  = req_sha[3*i +: 3];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // req_ready is gated by rst_n so nothing is offered while in reset.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        accept    = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_valid && rst_n) begin
                    req_ready = win_oh;
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = own_oh;
                if (|(rsp_ready & own_oh)) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bsh_in   <= '0;
            bsh_lr   <= 1'b0;
            bsh_sha  <= '0;
            grant_id <= '0;
        end else if (accept) begin
            bsh_in   <= sel_data;
            bsh_lr   <= sel_lr;
            bsh_sha  <= sel_sha;
            grant_id <= win_id;
        end
    end

    // Rotator output is sampled one cycle after issue; held through RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_data <= '0;
        end else if (state == ISSUE) begin
            rsp_data <= bsh_out;
        end
    end

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Self-checking bench for barrel_shift_arbiter (NREQ=4).
// Directed vector table, multi-cycle corner sequences and a randomized scoreboard.
module tb_barrel_shift_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_lr = '0;
    logic [3*N-1:0] req_sha = '0;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready = '0;
    logic [7:0]     rsp_data;
    logic [7:0]     bsh_in;
    logic           bsh_lr;
    logic [2:0]     bsh_sha;
    logic [7:0]     bsh_out;
    logic           busy;
    logic [1:0]     grant_id;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Reference rotator: repeated single-bit rotations.
    function automatic logic [7:0] rot(logic [7:0] d, logic lr, logic [2:0] s);
        logic [7:0] r;
        r = d;
        for (int i = 0; i < int'(s); i++) begin
            r = lr ? {r[0], r[7:1]} : {r[6:0], r[7]};
        end
        return r;
    endfunction

    assign bsh_out = rot(bsh_in, bsh_lr, bsh_sha);

    barrel_shift_arbiter #(.NREQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_lr    (req_lr),
        .req_sha   (req_sha),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .bsh_in    (bsh_in),
        .bsh_lr    (bsh_lr),
        .bsh_sha   (bsh_sha),
        .bsh_out   (bsh_out),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_cmd(input int id, input logic [7:0] d, input logic lr,
                           input logic [2:0] s);
        req_data[8*id +: 8] = d;
        req_lr[id]          = lr;
        req_sha[3*id +: 3]  = s;
    endtask

    // Winner rule: first valid at or after ptr (round-robin) or lowest index.
    function automatic int pick(logic [N-1:0] v, int ptr);
`ifdef BSH_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
`else
        for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
`endif
        return -1;
    endfunction

    typedef struct {
        int         id;
        logic [7:0] data;
        logic       lr;
        logic [2:0] sha;
        logic [7:0] exp;
    } vec_t;

    // Single isolated command: ready, issue, response, return to idle.
    task automatic run_op(input vec_t v);
        set_cmd(v.id, v.data, v.lr, v.sha);
        req_valid[v.id] = 1'b1;
        @(negedge clk);
        chk("op_ready", 32'(req_ready), 32'(1 << v.id));
        tick();
        req_valid[v.id] = 1'b0;
        chk("op_busy", 32'(busy), 32'd1);
        chk("op_grant", 32'(grant_id), 32'(v.id));
        chk("op_ready_off", 32'(req_ready), 32'd0);
        tick();
        chk("op_rsp_valid", 32'(rsp_valid), 32'(1 << v.id));
        chk("op_rsp_data", 32'(rsp_data), 32'(v.exp));
        rsp_ready[v.id] = 1'b1;
        tick();
        rsp_ready = '0;
        chk("op_idle", 32'(busy), 32'd0);
        chk("op_rsp_off", 32'(rsp_valid), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        int         ptr;
        int         w;
        int         n;
        int         bad;
        int         outst;
        int         owner;
        int         acc;
        int         done;
        logic [7:0] expd;
        logic [7:0] held;
        logic [N-1:0] pend;
        logic [7:0] cd[N];
        logic       cl[N];
        logic [2:0] cs[N];

        vecs[0] = '{0, 8'hB4, 1'b0, 3'd3, 8'hA5};
        vecs[1] = '{2, 8'h81, 1'b1, 3'd1, 8'hC0};
        vecs[2] = '{2, 8'h81, 1'b1, 3'd0, 8'h81};
        vecs[3] = '{1, 8'h01, 1'b0, 3'd7, 8'h80};
        vecs[4] = '{3, 8'hF0, 1'b1, 3'd4, 8'h0F};
        vecs[5] = '{1, 8'h3C, 1'b1, 3'd2, 8'h0F};

        // Reset state, checked while still in reset.
        req_valid = '1;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_bsh_in", 32'(bsh_in), 32'd0);
        chk("rst_bsh_ctl", 32'({bsh_lr, bsh_sha}), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_ready", 32'(req_ready), 32'd0);
        tick();

        // Directed vector table.
        for (int i = 0; i < 6; i++) run_op(vecs[i]);

        // Backpressure: owner 0 stalls, others' rsp_ready ignored, req2 waits.
        do_reset();
        set_cmd(0, 8'h5A, 1'b0, 3'd1);
        req_valid[0] = 1'b1;
        @(negedge clk);
        chk("bp_ready0", 32'(req_ready), 32'd1);
        tick();
        req_valid[0] = 1'b0;
        set_cmd(2, 8'h0F, 1'b0, 3'd4);
        req_valid[2] = 1'b1;
        rsp_ready = 4'b1110;
        tick();
        held = rsp_data;
        chk("bp_data", 32'(held), 32'h0B4);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_hold", 32'(rsp_data), 32'(held));
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
            tick();
        end
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = '0;
        @(negedge clk);
        chk("bp_next_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid[2] = 1'b0;
        tick();
        chk("bp_rsp2", 32'(rsp_data), 32'hF0);
        chk("bp_rsp2_valid", 32'(rsp_valid), 32'b0100);
        rsp_ready[2] = 1'b1;
        tick();
        rsp_ready = '0;

        // Reset while in ISSUE drops the command.
        set_cmd(1, 8'hAA, 1'b0, 3'd1);
        req_valid[1] = 1'b1;
        @(negedge clk);
        chk("ri_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid[1] = 1'b0;
        chk("ri_in_issue", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("ri_busy", 32'(busy), 32'd0);
        chk("ri_bsh", 32'({bsh_in, bsh_lr, bsh_sha}), 32'd0);
        chk("ri_rsp_data", 32'(rsp_data), 32'd0);
        chk("ri_grant", 32'(grant_id), 32'd0);
        chk("ri_rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        rsp_ready = '1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid != 0 || busy) bad++;
            tick();
        end
        chk("ri_no_rsp", 32'(bad), 32'd0);
        rsp_ready = '0;

        // Valid glitch from req1 while busy is never accepted.
        set_cmd(0, 8'h11, 1'b0, 3'd1);
        req_valid[0] = 1'b1;
        @(negedge clk);
        chk("gl_ready0", 32'(req_ready), 32'b0001);
        tick();
        req_valid[0] = 1'b0;
        set_cmd(1, 8'h77, 1'b1, 3'd3);
        req_valid[1] = 1'b1;
        tick();
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("gl_rsp0", 32'({rsp_valid, rsp_data}), 32'({4'b0001, 8'h22}));
        rsp_ready = '1;
        tick();
        rsp_ready = '0;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (req_ready != 0 || rsp_valid != 0 || busy) bad++;
            tick();
        end
        chk("gl_never", 32'(bad), 32'd0);

        // All four valid, rsp_ready tied high: grant order.
        do_reset();
        for (int i = 0; i < N; i++) set_cmd(i, 8'(i + 1), 1'b0, 3'd1);
        req_valid = '1;
        rsp_ready = '1;
        ptr = 0;
        n = 0;
        for (int c = 0; c < 30 && n < 5; c++) begin
            @(negedge clk);
            if (req_ready != 0) begin
                w = pick(req_valid, ptr);
                chk("rr_order", 32'(req_ready), 32'(1 << w));
                ptr = (w + 1) % N;
                n++;
            end
            tick();
        end
        chk("rr_count", 32'(n), 32'd5);
        req_valid = '0;
        rsp_ready = '0;

        // Randomized traffic against a transaction-level scoreboard.
        do_reset();
        ptr   = 0;
        outst = 0;
        owner = 0;
        acc   = 0;
        done  = -1;
        expd  = '0;
        pend  = '0;
        for (int i = 0; i < N; i++) begin
            cd[i] = '0;
            cl[i] = 1'b0;
            cs[i] = '0;
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            if (!outst && req_valid != 0 && cyc > done) begin
                w = pick(req_valid, ptr);
                chk("rnd_grant", 32'(req_ready), 32'(1 << w));
                outst = 1;
                owner = w;
                expd  = rot(cd[w], cl[w], cs[w]);
                acc   = cyc;
                pend[w] = 1'b0;
            end else begin
                chk("rnd_no_ready", 32'(req_ready), 32'd0);
            end
            if (outst && cyc >= acc + 2) begin
                chk("rnd_rsp_valid", 32'(rsp_valid), 32'(1 << owner));
                if (rsp_ready[owner]) begin
                    chk("rnd_rsp_data", 32'(rsp_data), 32'(expd));
                    outst = 0;
                    ptr   = (owner + 1) % N;
                    done  = cyc;
                end
            end else begin
                chk("rnd_rsp_quiet", 32'(rsp_valid), 32'd0);
            end
            tick();
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    cd[i] = 8'($urandom);
                    cl[i] = 1'($urandom);
                    cs[i] = 3'($urandom);
                    set_cmd(i, cd[i], cl[i], cs[i]);
                end
            end
            req_valid = pend;
            rsp_ready = N'($urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
